// File: rtl/cache_pkg.sv
// Shared cache-subsystem types: refill FSM states, default line layout and memory-op encodings.
// Optional feature macro used by the refill engine: CRITICAL_WORD_FIRST_EN.
package cache_pkg;

    localparam int unsigned CACHE_WORD_W     = 32;
    localparam int unsigned CACHE_LINE_WORDS = 4;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WRBACK,
        READ,
        COMMIT
    } refill_state_e;

    typedef logic [CACHE_LINE_WORDS-1:0][CACHE_WORD_W-1:0] line_t;

endpackage

// File: rtl/cache_refill_if.sv
// Controller/memory-side bundle of the refill engine; slave = engine, master = controller + memory.
// With CRITICAL_WORD_FIRST_EN defined the crit_valid/crit_word signals are added.
interface cache_refill_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4
);
    logic                         miss_req;
    logic                         miss_dirty;
    logic [ADDR_W-1:0]            miss_addr;
    logic [ADDR_W-1:0]            victim_addr;
    logic [LINE_WORDS*WORD_W-1:0] victim_line;
    logic                         busy;
    logic                         done;
    logic                         fill_we;
    logic [LINE_WORDS*WORD_W-1:0] fill_line;
    logic [ADDR_W-1:0]            mem_addr;
    logic [WORD_W-1:0]            mem_wdata;
    logic                         mem_we;
    logic [WORD_W-1:0]            mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
    logic                         crit_valid;
    logic [WORD_W-1:0]            crit_word;

    modport slave (
        input  miss_req, miss_dirty, miss_addr, victim_addr, victim_line, mem_rdata,
        output busy, done, fill_we, fill_line, mem_addr, mem_wdata, mem_we, crit_valid, crit_word
    );
    modport master (
        output miss_req, miss_dirty, miss_addr, victim_addr, victim_line, mem_rdata,
        input  busy, done, fill_we, fill_line, mem_addr, mem_wdata, mem_we, crit_valid, crit_word
    );
`else
    modport slave (
        input  miss_req, miss_dirty, miss_addr, victim_addr, victim_line, mem_rdata,
        output busy, done, fill_we, fill_line, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output miss_req, miss_dirty, miss_addr, victim_addr, victim_line, mem_rdata,
        input  busy, done, fill_we, fill_line, mem_addr, mem_wdata, mem_we
    );
`endif
endinterface

// File: rtl/cache_refill_engine_mem_hold_timer.sv
// Per-word memory hold timer: counts MEM_LAT cycles down to zero, flags the last one,
// and reloads itself so consecutive words are timed without a gap.
module mem_hold_timer #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load_i,
    input  logic run_i,
    output logic last_cycle_o
);
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_cycle_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (run_i && last_cycle_o)) begin
            cnt_d = RELOAD;
        end else if (run_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cache_refill_engine.sv
// Cache refill engine: optional dirty-victim write-back, word-by-word line refill, one-cycle commit.
// CRITICAL_WORD_FIRST_EN starts the refill at the missed word and adds crit_valid/crit_word.
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MEM_LAT    = 4
) (
    input  logic           clk,
    input  logic           rst_b,
    cache_refill_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
    localparam int unsigned BOFF_W = $clog2(WORD_W / 8);
    localparam int unsigned LOFF_W = IDX_W + BOFF_W;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] buf_t;

    refill_state_e     state_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic [ADDR_W-1:0] vbase_q;
    logic [ADDR_W-1:0] rbase_q;
    buf_t              vline_q;
    buf_t              rbuf_q;
    buf_t              rbuf_d;
    buf_t              fill_q;
    logic [IDX_W-1:0]  widx_q;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  start_d;
    logic [IDX_W-1:0]  rd_start;
    logic              accept;
    logic              timer_last;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        line_base = a & ~ADDR_W'((LINE_WORDS * WORD_W / 8) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        word_addr = base | (ADDR_W'(idx) << BOFF_W);
    endfunction

    assign accept   = (state_q == IDLE) && bus.miss_req;
    assign idx_next = widx_q + 1'b1;

    always_comb begin
        rbuf_d         = rbuf_q;
        rbuf_d[widx_q] = bus.mem_rdata;
    end

    mem_hold_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk          (clk),
        .rst_b        (rst_b),
        .load_i       (accept),
        .run_i        ((state_q == WRBACK) || (state_q == READ)),
        .last_cycle_o (timer_last)
    );

`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0]  start_q;
    logic              crit_valid_q;
    logic [WORD_W-1:0] crit_word_q;

    assign start_d  = bus.miss_addr[LOFF_W-1:BOFF_W];
    assign rd_start = start_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            start_q      <= '0;
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            if (accept) begin
                start_q <= start_d;
            end
            if ((state_q == READ) && timer_last && (widx_q == start_q)) begin
                crit_valid_q <= 1'b1;
                crit_word_q  <= bus.mem_rdata;
            end
        end
    end

    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_word  = crit_word_q;
`else
    assign start_d  = '0;
    assign rd_start = '0;
`endif

    // Read wrap ends on the word just before the start offset, so both builds read LINE_WORDS words.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= MEM_OP_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vbase_q     <= '0;
            rbase_q     <= '0;
            vline_q     <= '0;
            rbuf_q      <= '0;
            fill_q      <= '0;
            widx_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.miss_req) begin
                        busy_q  <= 1'b1;
                        vbase_q <= line_base(bus.victim_addr);
                        rbase_q <= line_base(bus.miss_addr);
                        vline_q <= bus.victim_line;
                        if (bus.miss_dirty) begin
                            state_q     <= WRBACK;
                            widx_q      <= '0;
                            mem_addr_q  <= line_base(bus.victim_addr);
                            mem_wdata_q <= bus.victim_line[WORD_W-1:0];
                            mem_we_q    <= MEM_OP_WRITE;
                        end else begin
                            state_q    <= READ;
                            widx_q     <= start_d;
                            mem_addr_q <= word_addr(line_base(bus.miss_addr), start_d);
                        end
                    end
                end
                WRBACK: begin
                    if (timer_last) begin
                        if (&widx_q) begin
                            state_q     <= READ;
                            widx_q      <= rd_start;
                            mem_addr_q  <= word_addr(rbase_q, rd_start);
                            mem_wdata_q <= '0;
                            mem_we_q    <= MEM_OP_READ;
                        end else begin
                            widx_q      <= idx_next;
                            mem_addr_q  <= word_addr(vbase_q, idx_next);
                            mem_wdata_q <= vline_q[idx_next];
                        end
                    end
                end
                READ: begin
                    if (timer_last) begin
                        rbuf_q <= rbuf_d;
                        if (idx_next == rd_start) begin
                            state_q    <= COMMIT;
                            done_q     <= 1'b1;
                            fill_q     <= rbuf_d;
                            mem_addr_q <= '0;
                        end else begin
                            widx_q     <= idx_next;
                            mem_addr_q <= word_addr(rbase_q, idx_next);
                        end
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fill_we   = done_q;
    assign bus.fill_line = fill_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: 4x4 instance for the main scenarios, 2-word/1-cycle
// instance for the minimum-latency case. Handles CRITICAL_WORD_FIRST_EN builds as well.
module tb_cache_refill_engine;
    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_refill_if #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4)) bus ();
    cache_refill_if #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(2)) bus2 ();

    cache_refill_engine #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .MEM_LAT(4)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    cache_refill_engine #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(2), .MEM_LAT(1)) dut2 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus2.slave)
    );

    // Memory for the 4x4 instance only returns real data on the 4th cycle of a read hold.
    logic [31:0] prev_addr = '0;
    logic        prev_rd   = 1'b0;
    int          hold      = 0;
    always @(posedge clk) begin
        #1;
        if (bus.busy && !bus.mem_we && prev_rd && (bus.mem_addr == prev_addr)) hold++;
        else hold = 0;
        prev_rd   = bus.busy && !bus.mem_we;
        prev_addr = bus.mem_addr;
        bus.mem_rdata = (hold == 3) ? (32'hC0DE_0000 | {16'h0, bus.mem_addr[15:0]}) : 32'hBAD0_BAD0;
    end

    assign bus2.mem_rdata = 32'hC0DE_0000 | {16'h0, bus2.mem_addr[15:0]};

    localparam logic [127:0] EXP_LINE_100 = 128'hC0DE010C_C0DE0108_C0DE0104_C0DE0100;
    localparam logic [127:0] VICTIM       = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;

    logic [31:0] exp_rd [4];
    logic [31:0] exp_wr [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    logic [31:0] exp_wd [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic dirty, input logic [31:0] maddr, input logic [31:0] vaddr,
                         input logic [127:0] vline);
        bus.miss_req    = 1'b1;
        bus.miss_dirty  = dirty;
        bus.miss_addr   = maddr;
        bus.victim_addr = vaddr;
        bus.victim_line = vline;
        tick();
        bus.miss_req = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.fill_we, bus.mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl busy/done/fill_we/mem_we=%b expected 0000",
                     {bus.busy, bus.done, bus.fill_we, bus.mem_we});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.fill_line !== 128'h0 || bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill fill_line=%h busy2=%b expected 0/0", bus.fill_line, bus2.busy);
        end
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_clean_miss();
        issue(1'b0, 32'h0000_0108, 32'h0, '0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (bus.mem_addr !== exp_rd[(c-1)/4] || bus.mem_we !== 1'b0 || bus.busy !== 1'b1 ||
                bus.done !== 1'b0) begin
                errors++;
                $display("FAIL clean_read c=%0d addr=%h we=%b busy=%b done=%b expected addr=%h we=0 busy=1 done=0",
                         c, bus.mem_addr, bus.mem_we, bus.busy, bus.done, exp_rd[(c-1)/4]);
            end
`ifdef CRITICAL_WORD_FIRST_EN
            checks++;
            if (bus.crit_valid !== (c == 5)) begin
                errors++;
                $display("FAIL crit_valid c=%0d got %b expected %b", c, bus.crit_valid, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (bus.crit_word !== 32'hC0DE0108) begin
                    errors++;
                    $display("FAIL crit_word got %h expected C0DE0108", bus.crit_word);
                end
            end
`endif
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.fill_we !== 1'b1 || bus.busy !== 1'b1 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL clean_commit done=%b fill_we=%b busy=%b addr=%h expected 1/1/1/0",
                     bus.done, bus.fill_we, bus.busy, bus.mem_addr);
        end
        checks++;
        if (bus.fill_line !== EXP_LINE_100) begin
            errors++;
            $display("FAIL clean_line got %h expected %h", bus.fill_line, EXP_LINE_100);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.fill_we !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_idle done=%b fill_we=%b busy=%b expected 0/0/0", bus.done, bus.fill_we, bus.busy);
        end
    endtask

    task automatic test_dirty_miss();
        issue(1'b1, 32'h0000_0108, 32'h0000_0200, VICTIM);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== exp_wr[(c-1)/4] || bus.mem_wdata !== exp_wd[(c-1)/4]) begin
                errors++;
                $display("FAIL dirty_write c=%0d we=%b addr=%h wdata=%h expected we=1 addr=%h wdata=%h",
                         c, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_wr[(c-1)/4], exp_wd[(c-1)/4]);
            end
            tick();
        end
        for (int c = 17; c <= 32; c++) begin
            checks++;
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== exp_rd[(c-17)/4] || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL dirty_read c=%0d we=%b addr=%h done=%b expected we=0 addr=%h done=0",
                         c, bus.mem_we, bus.mem_addr, bus.done, exp_rd[(c-17)/4]);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.fill_we !== 1'b1 || bus.fill_line !== EXP_LINE_100) begin
            errors++;
            $display("FAIL dirty_commit done=%b fill_we=%b line=%h expected 1/1/%h",
                     bus.done, bus.fill_we, bus.fill_line, EXP_LINE_100);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL dirty_idle busy=%b wdata=%h expected 0/0", bus.busy, bus.mem_wdata);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int nbad  = 0;
        int first = 0;
        int second = 0;
        bus.miss_req   = 1'b1;
        bus.miss_dirty = 1'b0;
        bus.miss_addr  = 32'h0000_0300;
        tick();
        for (int c = 1; c <= 40; c++) begin
            if (bus.fill_we !== bus.done) nbad++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 1) first = c;
                if (ndone == 2) second = c;
            end
            if (c == 18) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap busy=%b expected 0 at c=18", bus.busy);
                end
            end
            if (c == 19) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_reaccept busy=%b expected 1 at c=19", bus.busy);
                end
                bus.miss_req = 1'b0;
            end
            tick();
        end
        checks++;
        if (ndone != 2 || first != 17 || second != 35) begin
            errors++;
            $display("FAIL b2b_done count=%0d first=%0d second=%0d expected 2/17/35", ndone, first, second);
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL b2b_fill_we cycles with fill_we!=done: %0d expected 0", nbad);
        end
    endtask

    task automatic test_reset_mid();
        int nfill = 0;
        logic [31:0] exp_a;
        issue(1'b0, 32'h0000_0108, 32'h0, '0);
        for (int c = 1; c < 10; c++) tick();
        exp_a = exp_rd[2];
        checks++;
        if (bus.mem_addr !== exp_a || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre addr=%h busy=%b expected %h/1", bus.mem_addr, bus.busy, exp_a);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.fill_we, bus.mem_we} !== 4'b0000 || bus.mem_addr !== 32'h0 ||
            bus.fill_line !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_async busy/done/fill_we/we=%b addr=%h line=%h expected 0",
                     {bus.busy, bus.done, bus.fill_we, bus.mem_we}, bus.mem_addr, bus.fill_line);
        end
        tick();
        tick();
        rst_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.fill_we !== 1'b0 || bus.busy !== 1'b0) nfill++;
            tick();
        end
        checks++;
        if (nfill != 0) begin
            errors++;
            $display("FAIL rstmid_abort cycles with fill_we/busy after reset: %0d expected 0", nfill);
        end
        issue(1'b0, 32'h0000_0108, 32'h0, '0);
        for (int c = 1; c < 17; c++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.fill_line !== EXP_LINE_100) begin
            errors++;
            $display("FAIL rstmid_retry done=%b line=%h expected 1/%h", bus.done, bus.fill_line, EXP_LINE_100);
        end
        tick();
    endtask

    task automatic test_min_latency();
        logic [31:0] a0;
        logic [31:0] a1;
`ifdef CRITICAL_WORD_FIRST_EN
        a0 = 32'h404;
        a1 = 32'h400;
`else
        a0 = 32'h400;
        a1 = 32'h404;
`endif
        bus2.miss_req   = 1'b1;
        bus2.miss_dirty = 1'b0;
        bus2.miss_addr  = 32'h0000_0404;
        tick();
        for (int c = 1; c <= 8; c++) begin
            case (c)
                1, 2: begin
                    checks++;
                    if (bus2.mem_addr !== ((c == 1) ? a0 : a1) || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
                        errors++;
                        $display("FAIL small_read c=%0d addr=%h busy=%b done=%b expected %h/1/0",
                                 c, bus2.mem_addr, bus2.busy, bus2.done, (c == 1) ? a0 : a1);
                    end
                end
                3, 7: begin
                    checks++;
                    if (bus2.done !== 1'b1 || bus2.fill_we !== 1'b1 ||
                        bus2.fill_line !== 64'hC0DE0404_C0DE0400) begin
                        errors++;
                        $display("FAIL small_commit c=%0d done=%b fill_we=%b line=%h expected 1/1/C0DE0404C0DE0400",
                                 c, bus2.done, bus2.fill_we, bus2.fill_line);
                    end
                end
                4, 8: begin
                    checks++;
                    if (bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin
                        errors++;
                        $display("FAIL small_idle c=%0d busy=%b done=%b expected 0/0", c, bus2.busy, bus2.done);
                    end
                end
                5: begin
                    checks++;
                    if (bus2.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL small_b2b busy=%b expected 1 at c=5", bus2.busy);
                    end
                    bus2.miss_req = 1'b0;
                end
                default: ;
            endcase
            tick();
        end
    endtask

    initial begin
`ifdef CRITICAL_WORD_FIRST_EN
        exp_rd = '{32'h108, 32'h10C, 32'h100, 32'h104};
`else
        exp_rd = '{32'h100, 32'h104, 32'h108, 32'h10C};
`endif
        bus.miss_req     = 1'b0;
        bus.miss_dirty   = 1'b0;
        bus.miss_addr    = '0;
        bus.victim_addr  = '0;
        bus.victim_line  = '0;
        bus2.miss_req    = 1'b0;
        bus2.miss_dirty  = 1'b0;
        bus2.miss_addr   = '0;
        bus2.victim_addr = '0;
        bus2.victim_line = '0;

        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid();
        test_min_latency();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
